// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with sized loads/stores and a valid/ready request port.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (alignment / range fault detection at accept).
module data_memory_sized #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [63:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Fault,
  output logic [1:0]            dbg_state
);

  // Handshake: a request is accepted on a rising edge where ReqValid && ReqReady;
  // ReqReady is high only in IDLE, and every accepted request yields exactly one
  // RespValid pulse (unless reset intervenes before commit).

  localparam int MAX_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [7:0] mem [0:DEPTH-1];

  logic                  lat_write;
  logic                  lat_signed;
  logic [3:0]            lat_bytes;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_fault;

  logic                  accept;
  logic [3:0]            req_bytes;
  logic                  req_fault;

  logic [DATA_WIDTH-1:0] load_raw;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  sign_bit;

  assign accept = ReqValid && ReqReady;

  // Access width in bytes, clamped to the data port width.
  always_comb begin
    req_bytes = 4'd1;
    case (ReqSize)
      2'b00:   req_bytes = 4'd1;
      2'b01:   req_bytes = 4'd2;
      2'b10:   req_bytes = 4'd4;
      default: req_bytes = 4'd8;
    endcase
    if (req_bytes > 4'(MAX_BYTES)) req_bytes = 4'(MAX_BYTES);
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_fault = ((Address & ({60'd0, req_bytes} - 64'd1)) != 64'd0) ||
                     (Address[63:ADDR_WIDTH] != '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[63:ADDR_WIDTH];
  assign req_fault      = 1'b0;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      lat_write  <= 1'b0;
      lat_signed <= 1'b0;
      lat_bytes  <= 4'd0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_fault  <= 1'b0;
      ReadData   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        lat_write  <= ReqWrite;
        lat_signed <= ReqSigned;
        lat_bytes  <= req_bytes;
        lat_addr   <= Address[ADDR_WIDTH-1:0];
        lat_wdata  <= WriteData;
        lat_fault  <= req_fault;
      end
      // Store responses keep the last load result visible.
      if (state_q == S_COMMIT) begin
        if (lat_fault) ReadData <= '0;
        else if (!lat_write) ReadData <= load_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_WAIT;
            wait_d  = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = S_COMMIT;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_COMMIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ReqReady  = (state_q == S_IDLE);
  assign RespValid = (state_q == S_RESP);
  assign Fault     = RespValid && lat_fault;
  assign dbg_state = state_q;

  // Byte k of the access sits at lat_addr+k (wrapping) and lands in the k-th most significant byte.
  always_comb begin
    load_raw = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (k < int'(lat_bytes))
        load_raw[8*(int'(lat_bytes)-k-1) +: 8] = mem[lat_addr + ADDR_WIDTH'(k)];
    end
    sign_bit = 1'b0;
    for (int b = 1; b <= MAX_BYTES; b++) begin
      if (int'(lat_bytes) == b) sign_bit = load_raw[8*b-1];
    end
    load_ext = load_raw;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= 8*int'(lat_bytes)) load_ext[i] = lat_signed && sign_bit;
    end
  end

  // RAM contents are never reset; the ResetN term drops a commit racing a reset.
  always_ff @(posedge Clock) begin
    if (ResetN && (state_q == S_COMMIT) && lat_write && !lat_fault) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (k < int'(lat_bytes))
          mem[lat_addr + ADDR_WIDTH'(k)] <= lat_wdata[8*(int'(lat_bytes)-k-1) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: three instances (WAIT_STATES 1, 0, 4) share one stimulus
// stream so latency, data and reset behaviour are checked side by side.
module tb_data_memory_sized;

  logic        Clock;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [63:0] Address;
  logic [63:0] WriteData;

  logic [2:0]  req_ready;
  logic [2:0]  resp_valid;
  logic [2:0]  fault;
  logic [63:0] read_data [3];
  logic [1:0]  dbg [3];

  int checks   = 0;
  int failures = 0;
  int exp_lat [3] = '{2, 1, 5};
  logic [63:0] held_rd = 64'd0;

  data_memory_sized #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WAIT_STATES(1)) dut_ws1 (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(req_ready[0]),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
    .WriteData(WriteData), .RespValid(resp_valid[0]), .ReadData(read_data[0]),
    .Fault(fault[0]), .dbg_state(dbg[0])
  );

  data_memory_sized #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WAIT_STATES(0)) dut_ws0 (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(req_ready[1]),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
    .WriteData(WriteData), .RespValid(resp_valid[1]), .ReadData(read_data[1]),
    .Fault(fault[1]), .dbg_state(dbg[1])
  );

  data_memory_sized #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WAIT_STATES(4)) dut_ws4 (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(req_ready[2]),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
    .WriteData(WriteData), .RespValid(resp_valid[2]), .ReadData(read_data[2]),
    .Fault(fault[2]), .dbg_state(dbg[2])
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_ready%0d", tag, i), {63'd0, req_ready[i]}, 64'd1);
      chk($sformatf("%s_resp%0d", tag, i), {63'd0, resp_valid[i]}, 64'd0);
      chk($sformatf("%s_rdata%0d", tag, i), read_data[i], 64'd0);
      chk($sformatf("%s_fault%0d", tag, i), {63'd0, fault[i]}, 64'd0);
    end
  endtask

  // driver: one request, then watch every instance for its single response pulse
  task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_flt);
    int lat [3];
    int pulses [3];
    @(negedge Clock);
    chk({tag, "_ready"}, {61'd0, req_ready}, 64'h7);
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqSize   = sz;
    ReqSigned = sg;
    Address   = addr;
    WriteData = wd;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    chk({tag, "_busy"}, {61'd0, req_ready}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      lat[i]    = 0;
      pulses[i] = 0;
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge Clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (resp_valid[i]) begin
          pulses[i]++;
          if (lat[i] == 0) begin
            lat[i] = c;
            chk($sformatf("%s_rdata%0d", tag, i), read_data[i], exp_rd);
            chk($sformatf("%s_fault%0d", tag, i), {63'd0, fault[i]}, {63'd0, exp_flt});
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lat%0d", tag, i), 64'(lat[i]), 64'(exp_lat[i]));
      chk($sformatf("%s_pulses%0d", tag, i), 64'(pulses[i]), 64'd1);
    end
    held_rd = exp_rd;
  endtask

  initial begin
    int pulses_rst;
    ResetN    = 1'b0;
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    ReqSize   = 2'b00;
    ReqSigned = 1'b0;
    Address   = 64'd0;
    WriteData = 64'd0;
    repeat (3) @(negedge Clock);
    chk_idle_outputs("reset");
    chk("reset_state", {62'd0, dbg[0]}, 64'd0);
    ResetN = 1'b1;

    // double store / load round trip, sized loads with extension
    access("st_d10", 1'b1, 2'b11, 1'b0, 64'h10, 64'h0123456789ABCDEF, held_rd, 1'b0);
    access("ld_d10", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h0123456789ABCDEF, 1'b0);
    access("ld_b10_u", 1'b0, 2'b00, 1'b0, 64'h10, 64'd0, 64'h01, 1'b0);
    access("ld_b14_s", 1'b0, 2'b00, 1'b1, 64'h14, 64'd0, 64'hFFFFFFFFFFFFFF89, 1'b0);
    access("ld_b14_u", 1'b0, 2'b00, 1'b0, 64'h14, 64'd0, 64'h0000000000000089, 1'b0);
    access("ld_w10_s", 1'b0, 2'b10, 1'b1, 64'h10, 64'd0, 64'h0000000001234567, 1'b0);

    // half store touches exactly two bytes
    access("st_d18", 1'b1, 2'b11, 1'b0, 64'h18, 64'd0, held_rd, 1'b0);
    access("st_d20", 1'b1, 2'b11, 1'b0, 64'h20, 64'd0, held_rd, 1'b0);
    access("st_h20", 1'b1, 2'b01, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_BEEF, held_rd, 1'b0);
    access("ld_b1f", 1'b0, 2'b00, 1'b0, 64'h1F, 64'd0, 64'h00, 1'b0);
    access("ld_b20", 1'b0, 2'b00, 1'b0, 64'h20, 64'd0, 64'hBE, 1'b0);
    access("ld_b21", 1'b0, 2'b00, 1'b0, 64'h21, 64'd0, 64'hEF, 1'b0);
    access("ld_b22", 1'b0, 2'b00, 1'b0, 64'h22, 64'd0, 64'h00, 1'b0);
    access("ld_h20_u", 1'b0, 2'b01, 1'b0, 64'h20, 64'd0, 64'hBEEF, 1'b0);
    access("ld_h20_s", 1'b0, 2'b01, 1'b1, 64'h20, 64'd0, 64'hFFFFFFFFFFFFBEEF, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    access("ld_w22_flt", 1'b0, 2'b10, 1'b0, 64'h22, 64'd0, 64'd0, 1'b1);
    access("st_w10010_flt", 1'b1, 2'b10, 1'b0, 64'h1_0010, 64'hCAFEBABE, 64'd0, 1'b1);
    access("ld_w10_after", 1'b0, 2'b10, 1'b0, 64'h10, 64'd0, 64'h01234567, 1'b0);
`else
    access("ld_h21_mis", 1'b0, 2'b01, 1'b0, 64'h21, 64'd0, 64'hEF00, 1'b0);
    access("ld_b10010", 1'b0, 2'b00, 1'b0, 64'h1_0010, 64'd0, 64'h01, 1'b0);
    access("st_dfffc", 1'b1, 2'b11, 1'b0, 64'hFFFC, 64'h1122334455667788, held_rd, 1'b0);
    access("ld_wfffc", 1'b0, 2'b10, 1'b0, 64'hFFFC, 64'd0, 64'h11223344, 1'b0);
    access("ld_w0000", 1'b0, 2'b10, 1'b0, 64'h0000, 64'd0, 64'h55667788, 1'b0);
    access("ld_dfffc", 1'b0, 2'b11, 1'b0, 64'hFFFC, 64'd0, 64'h1122334455667788, 1'b0);
`endif

    // reset while a store is in flight drops it
    access("st_d30", 1'b1, 2'b11, 1'b0, 64'h30, 64'hA5A5A5A5A5A5A5A5, held_rd, 1'b0);
    @(negedge Clock);
    ReqValid  = 1'b1;
    ReqWrite  = 1'b1;
    ReqSize   = 2'b11;
    ReqSigned = 1'b0;
    Address   = 64'h30;
    WriteData = 64'h5A5A5A5A5A5A5A5A;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    ResetN   = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    pulses_rst = 0;
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock);
      #1;
      if (resp_valid != 3'b000) pulses_rst++;
    end
    chk("rst_no_resp", 64'(pulses_rst), 64'd0);
    chk_idle_outputs("rst_after");
    held_rd = 64'd0;
    access("ld_d30", 1'b0, 2'b11, 1'b0, 64'h30, 64'd0, 64'hA5A5A5A5A5A5A5A5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
